// File: rtl/seg_display_scheduler_if.sv
// Bundle between the requester channels and seg_display_scheduler.
// master: requester/userspace side, slave: the scheduler.
interface seg_display_scheduler_if;
    logic [3:0]   req;
    logic [3:0]   urgent;
    logic         manual;
    logic         next;
    logic [127:0] ch_content;
    logic [31:0]  ch_dp;
    logic [31:0]  ch_en;
    logic [31:0]  blink_mask;
    logic [3:0]   gnt;
    logic [1:0]   owner;
    logic         valid;
    logic [31:0]  seg_content;
    logic [7:0]   seg_dp;
    logic [7:0]   seg_en;

    modport master (
        output req, urgent, manual, next, ch_content, ch_dp, ch_en, blink_mask,
        input  gnt, owner, valid, seg_content, seg_dp, seg_en
    );

    modport slave (
        input  req, urgent, manual, next, ch_content, ch_dp, ch_en, blink_mask,
        output gnt, owner, valid, seg_content, seg_dp, seg_en
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Time-shares the 8-digit 7-segment display among four requesters (round-robin, manual step, urgent preemption).
// Optional digit blinking is enabled by defining SEG_BLINK_EN.
module seg_display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 200_000_000,
    parameter int unsigned BLINK_HALF   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    seg_display_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ROTATE, PREEMPT} state_t;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  owner, owner_n;
    logic [1:0]  saved, saved_n;
    logic [31:0] dwell, dwell_n;
    logic [3:0]  gnt;
    logic        valid;
    logic [3:0]  urg;

    logic [31:0] seg_content_p1;
    logic [7:0]  seg_dp_p1;
    logic [7:0]  seg_en_p1;
    logic [7:0]  blank_mask;
    logic [6:0]  cbase;
    logic [4:0]  ebase;

    // First i with r[i] searching upward from ref_idx+1; ref_idx itself comes last.
    function automatic logic [1:0] rr_pick(input logic [1:0] ref_idx, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = ref_idx;
        for (int k = 4; k >= 1; k--) begin
            idx = ref_idx + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        lowest = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) lowest = 2'(k);
        end
    endfunction

    assign urg = bus.urgent & bus.req;

    always_comb begin
        state_n = state;
        owner_n = owner;
        saved_n = saved;
        dwell_n = dwell;
        unique case (state)
            IDLE: begin
                if (|urg) begin
                    state_n = PREEMPT;
                    owner_n = lowest(urg);
                    saved_n = 2'd0;
                    dwell_n = '0;
                end else if (|bus.req) begin
                    state_n = ROTATE;
                    owner_n = rr_pick(owner, bus.req);
                    dwell_n = '0;
                end
            end
            ROTATE: begin
                if (|urg) begin
                    state_n = PREEMPT;
                    owner_n = lowest(urg);
                    saved_n = owner;
                    dwell_n = '0;
                end else if (bus.req == 4'd0) begin
                    state_n = IDLE;
                    dwell_n = '0;
                end else if (!bus.req[owner] || bus.next ||
                             (!bus.manual && dwell == DWELL_LAST)) begin
                    owner_n = rr_pick(owner, bus.req);
                    dwell_n = '0;
                end else if (!bus.manual) begin
                    dwell_n = dwell + 32'd1;
                end
            end
            PREEMPT: begin
                dwell_n = '0;
                if (|urg) begin
                    // Another urgent channel still pending keeps us preempted; lowest index wins.
                    owner_n = lowest(urg);
                end else if (bus.req == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    state_n = ROTATE;
                    owner_n = bus.req[saved] ? saved : rr_pick(saved, bus.req);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: arbitration state and registered grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            saved <= 2'd0;
            dwell <= '0;
            gnt   <= 4'd0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            saved <= saved_n;
            dwell <= dwell_n;
            valid <= (state_n != IDLE);
            gnt   <= (state_n != IDLE) ? (4'b0001 << owner_n) : 4'd0;
        end
    end

    assign cbase = {owner, 5'd0};
    assign ebase = {owner, 3'd0};

`ifdef SEG_BLINK_EN
    logic        phase;
    logic [31:0] blink_cnt;
    logic        own_chg;

    assign own_chg    = (state_n != IDLE) && ((state == IDLE) || (owner_n != owner));
    assign blank_mask = bus.blink_mask[ebase +: 8] & {8{phase}};

    always_ff @(posedge clk) begin
        if (rst || own_chg) begin
            phase     <= 1'b0;
            blink_cnt <= '0;
        end else if (blink_cnt == 32'(BLINK_HALF - 1)) begin
            phase     <= ~phase;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end
`else
    logic unused_blink;

    assign unused_blink = (^bus.blink_mask) ^ (BLINK_HALF == 0);
    assign blank_mask   = 8'd0;
`endif

    // Stage p1: display data follows the registered owner by one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_content_p1 <= '0;
            seg_dp_p1      <= '0;
            seg_en_p1      <= '0;
        end else if (valid) begin
            seg_content_p1 <= bus.ch_content[cbase +: 32];
            seg_dp_p1      <= bus.ch_dp[ebase +: 8];
            seg_en_p1      <= bus.ch_en[ebase +: 8] & ~blank_mask;
        end else begin
            seg_content_p1 <= '0;
            seg_dp_p1      <= '0;
            seg_en_p1      <= '0;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.owner       = owner;
    assign bus.valid       = valid;
    assign bus.seg_content = seg_content_p1;
    assign bus.seg_dp      = seg_dp_p1;
    assign bus.seg_en      = seg_en_p1;

endmodule
